// File: rtl/dataflow_merge_arbiter.sv
// Round-robin merge node: pulls one token at a time from up to num_inputs upstream
// req/ack channels and delivers it to a single downstream req/ack consumer. A per-fetch
// timeout releases a stalled source so it cannot block the shared downstream resource.
module dataflow_merge_arbiter #(
   parameter int unsigned data_width     = 32,
   parameter int unsigned num_inputs     = 4,
   parameter int unsigned timeout_cycles = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [num_inputs-1:0]            enable,
   output logic [num_inputs-1:0]            req_in,
   input  logic [num_inputs-1:0]            ack_in,
   input  logic [data_width*num_inputs-1:0] din,
   input  logic                             dout_req,
   output logic                             dout_ack,
   output logic [data_width-1:0]            dout,
   output logic [$clog2(num_inputs)-1:0]    dout_id,
   output logic [15:0]                      timeout_count
);

   localparam int unsigned IdW  = $clog2(num_inputs);
   localparam int unsigned PosW = IdW + 1;
   localparam int unsigned CntW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;

   localparam logic [PosW-1:0] NumIn    = PosW'(num_inputs);
   localparam logic [IdW-1:0]  LastId   = IdW'(num_inputs - 1);
   localparam logic [CntW-1:0] WaitLast = (timeout_cycles > 0) ? CntW'(timeout_cycles - 1) : '0;

   typedef enum logic [1:0] {StIdle, StFetch, StSend} state_e;

   state_e                state_q, state_d;
   logic [IdW-1:0]        ptr_q, ptr_d;
   logic [IdW-1:0]        grant_q, grant_d;
   logic [CntW-1:0]       wait_q, wait_d;
   logic [data_width-1:0] hold_q, hold_d;
   logic [num_inputs-1:0] req_q, req_d;
   logic                  ack_q, ack_d;
   logic [data_width-1:0] dout_q, dout_d;
   logic [IdW-1:0]        id_q, id_d;
   logic [15:0]           tmo_q, tmo_d;

   logic                  pick_valid;
   logic [IdW-1:0]        pick_idx;
   logic [PosW-1:0]       pos;
   logic [IdW-1:0]        grant_next;
   logic [data_width-1:0] din_ch [num_inputs];

   for (genvar i = 0; i < num_inputs; i++) begin : g_din
      assign din_ch[i] = din[data_width*i +: data_width];
   end

   // Successor of the current grant, wrapping to channel 0.
   assign grant_next = (grant_q == LastId) ? '0 : grant_q + 1'b1;

   // Cyclic first-enabled search from the pointer; scanning backwards leaves the nearest hit.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      pos        = '0;
      for (int k = num_inputs - 1; k >= 0; k--) begin
         pos = {1'b0, ptr_q} + PosW'(k);
         if (pos >= NumIn) begin
            pos = pos - NumIn;
         end
         if (enable[pos[IdW-1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = pos[IdW-1:0];
         end
      end
   end

   // Next-state and registered-output logic for the IDLE/FETCH/SEND handshake.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      wait_d  = wait_q;
      hold_d  = hold_q;
      req_d   = req_q;
      ack_d   = 1'b0;
      dout_d  = dout_q;
      id_d    = id_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         StIdle: begin
            if (dout_req && pick_valid) begin
               grant_d           = pick_idx;
               req_d             = '0;
               req_d[pick_idx]   = 1'b1;
               wait_d            = '0;
               state_d           = StFetch;
            end
         end
         StFetch: begin
            // An ack in the timeout cycle still wins.
            if (ack_in[grant_q]) begin
               hold_d  = din_ch[grant_q];
               req_d   = '0;
               state_d = StSend;
            end else if ((timeout_cycles != 0) && (wait_q == WaitLast)) begin
               req_d   = '0;
               ptr_d   = grant_next;
               state_d = StIdle;
               if (tmo_q != 16'hFFFF) begin
                  tmo_d = tmo_q + 16'd1;
               end
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         StSend: begin
            // Token is held indefinitely until the consumer asks for it.
            if (dout_req && !ack_q) begin
               ack_d   = 1'b1;
               dout_d  = hold_q;
               id_d    = grant_q;
               ptr_d   = grant_next;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         grant_q <= '0;
         wait_q  <= '0;
         hold_q  <= '0;
         req_q   <= '0;
         ack_q   <= 1'b0;
         dout_q  <= '0;
         id_q    <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         wait_q  <= wait_d;
         hold_q  <= hold_d;
         req_q   <= req_d;
         ack_q   <= ack_d;
         dout_q  <= dout_d;
         id_q    <= id_d;
         tmo_q   <= tmo_d;
      end
   end

   assign req_in        = req_q;
   assign dout_ack      = ack_q;
   assign dout          = dout_q;
   assign dout_id       = id_q;
   assign timeout_count = tmo_q;

endmodule

// File: doc/dataflow_merge_arbiter.md
# dataflow_merge_arbiter

Round-robin merge node for the asynchronous dataflow fabric. It pulls tokens from up to `num_inputs` upstream operator/producer channels and presents them, one at a time, to a single downstream consumer channel, using the same req/ack pull handshake as the dataflow operators. The block lets several producers share one downstream operator, such as a single `out` node or one arithmetic unit. A per-fetch timeout skips stalled sources so one dead channel cannot block the shared resource.

## Interface
- `data_width`, 32: token width in bits.
- `num_inputs`, 4: number of upstream channels (2..16).
- `timeout_cycles`, 16: maximum cycles spent in FETCH waiting for `ack_in`; 0 disables the timeout.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: reset, synchronous, active-low (asserted when 0).
- `enable` input num_inputs: per-channel participation mask; bit i=0 excludes channel i from arbitration.
- `req_in` output num_inputs: pull request to upstream channel i; at most one bit high at any time.
- `ack_in` input num_inputs: one-cycle data-valid strobe from upstream channel i.
- `din` input data_width*num_inputs: upstream data; channel i occupies bits [data_width*(i+1)-1 : data_width*i].
- `dout_req` input 1: downstream pull request (level).
- `dout_ack` output 1: one-cycle strobe; `dout`/`dout_id` are valid while high.
- `dout` output data_width: delivered token.
- `dout_id` output clog2(num_inputs): index of the channel that sourced `dout`.
- `timeout_count` output 16: count of fetches abandoned by timeout; saturates at 16'hFFFF.

## Operation
- All outputs are registered.
- Reset values: `req_in`=0, `dout_ack`=0, `dout`=0, `dout_id`=0, `timeout_count`=0, rr pointer=0, state=IDLE.
- States are IDLE, FETCH and SEND.
- **IDLE**
  - If `dout_req`=1 and `enable`≠0: grant = first index g with `enable[g]`=1, searching cyclically from the pointer. Then set `req_in[g]`<=1, clear the wait counter and go to FETCH.
  - Otherwise stay in IDLE.
- **FETCH**
  - If `ack_in[g]`=1: capture the channel-g slice of `din` into the hold register, set `req_in[g]`<=0 and go to SEND.
  - Else if `timeout_cycles`≠0 and the wait counter equals `timeout_cycles`-1: set `req_in[g]`<=0, pointer<=g+1 (mod num_inputs), increment `timeout_count` (saturating) and go to IDLE.
  - Else increment the wait counter.
  - If ack and timeout occur in the same cycle, the ack wins.
- **SEND**
  - If `dout_req`=1 and `dout_ack`=0: set `dout_ack`<=1, `dout`<=hold, `dout_id`<=g, pointer<=g+1 (mod num_inputs; wraps num_inputs-1→0) and go to IDLE.
  - Otherwise hold. The token is never dropped, however long `dout_req` stays low.
- `dout_ack` is cleared on the cycle after it is set; `dout`/`dout_id` keep their last value.
- `ack_in` bits of non-granted channels, and any `ack_in` seen outside FETCH, are ignored and their data discarded.
  - Known limitation: an upstream ack arriving the cycle after a timeout release is lost.
- `enable` is sampled only in IDLE; clearing `enable[g]` during FETCH or SEND does not abort the transfer.
- Reset mid-operation clears all state on that edge. An in-flight token is discarded and arbitration restarts from pointer 0.

## Timing
- Edge E0: IDLE samples `dout_req`=1, and `req_in[g]` rises after E0.
- Edge E1: a registered upstream producer asserts `ack_in`.
- Edge E2: capture; `req_in` falls.
- Edge E3: `dout_ack` rises.
- Latency is 4 edges from `dout_req` sample to `dout_ack` high.
- Peak throughput is one token per 4 cycles with always-ready upstream and downstream: `dout_ack` then pulses every 4th cycle.
- A timed-out fetch costs `timeout_cycles`+1 cycles before the next grant.
- `dout_req` is not re-sampled until the cycle after `dout_ack` is set (IDLE).

## Test plan
- Reset: hold `rst`=0 for 3 cycles, then release -> all outputs 0, no `req_in` for any `dout_req` until release; first grant goes to channel 0.
- Two sources, num_inputs=4, `enable`=4'b0101, ch0 counts from 100, ch2 from 200, consumer always requesting -> `dout_id` sequence 0,2,0,2; `dout` sequence 100,200,101,201; `dout_ack` every 4th cycle.
- All enabled, all ready -> `dout_id` 0,1,2,3,0,1; pointer wrap verified; never two `req_in` bits high.
- Channel 1 never acks, `timeout_cycles`=8, all enabled -> `req_in[1]` high exactly 8 cycles then low; `timeout_count`=1; next `dout_id` is 2; repeating the run gives `timeout_count` incrementing once per rotation.
- Downstream stall: `dout_req` held low for 20 cycles in SEND -> no `dout_ack`; when raised, `dout_ack` fires on the next edge with the held token; no token lost or duplicated over 5000 tokens, checked by scoreboard against producer counts.
- `enable`=0 with `dout_req`=1 -> stays IDLE, `req_in`=0. Reset asserted mid-FETCH -> `req_in` clears next edge, and after release the first grant is channel 0.
